pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Decides, each cycle, which

---
 rtl/pipe_hazard_if.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 70 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: pipeline-to-hazard-controller signal bundle
interface pipe_hazard_if #(parameter int REG_ADDR_W = 5, parameter int CNT_W = 32);
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic id_rs1_used;
  logic id_rs2_used;
  logic id_branch;
  logic ex_rmem_en;
  logic [REG_ADDR_W-1:0] ex_wreg_addr;
  logic mem_req;
  logic dmem_ready;
  logic [3:0] stall;
  logic [3:0] flush;
  logic redirect_en;
  logic bus_err;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_branch,
    output ex_rmem_en, ex_wreg_addr, mem_req, dmem_ready,
    input stall, flush, redirect_en, bus_err, stall_cnt
  );
  modport slave (
    input id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_branch,
    input ex_rmem_en, ex_wreg_addr, mem_req, dmem_ready,
    output stall, flush, redirect_en, bus_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-cycle hold/flush decisions for the 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  pipe_hazard_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic {RUN, MWAIT} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic hazard;
  assign hazard = bus.ex_rmem_en && (bus.ex_wreg_addr != {REG_ADDR_W{1'b0}}) &&
                  ((bus.id_rs1_used && bus.id_rs1_addr == bus.ex_wreg_addr) ||
                   (bus.id_rs2_used && bus.id_rs2_addr == bus.ex_wreg_addr));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end
  // memory wait outranks load-use, which outranks redirect; reset forces all outputs low
  always_comb begin
    state_nxt = state;
    wait_nxt = wait_cnt;
    bus.stall = 4'b0000;
    bus.flush = 4'b0000;
    bus.redirect_en = 1'b0;
    bus.bus_err = 1'b0;
    if (!rst_n) begin
      state_nxt = RUN;
    end else if (state == MWAIT) begin
      if (bus.dmem_ready) begin
        state_nxt = RUN;
        wait_nxt = '0;
      end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
        bus.stall = 4'b0111;
        bus.flush = 4'b1100;
        bus.bus_err = 1'b1;
        state_nxt = RUN;
        wait_nxt = '0;
      end else begin
        bus.stall = 4'b1111;
        bus.flush = 4'b1000;
        wait_nxt = wait_cnt + 1'b1;
      end
    end else if (bus.mem_req && !bus.dmem_ready) begin
      bus.stall = 4'b1111;
      bus.flush = 4'b1000;
      state_nxt = MWAIT;
      wait_nxt = WW'(1);
    end else if (hazard) begin
      bus.stall = 4'b0011;
      bus.flush = 4'b0010;
    end else if (bus.id_branch) begin
      bus.redirect_en = 1'b1;
      bus.flush = 4'b0001;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.stall_cnt <= '0;
    else if (bus.stall[0] && bus.stall_cnt != {CNT_W{1'b1}}) bus.stall_cnt <= bus.stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for the hazard controller (TIMEOUT=4, CNT_W=4)
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pipe_hazard_if #(.REG_ADDR_W(5), .CNT_W(4)) bus();
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  typedef struct {
    string tag;
    logic [3:0] stall;
    logic [3:0] flush;
    logic redirect;
    logic bus_err;
    logic [3:0] cnt;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] mcnt = 4'd0;
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic br, input logic ld, input logic [4:0] wd, input logic req,
                       input logic rdy);
    bus.id_rs1_addr = rs1;
    bus.id_rs2_addr = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_branch = br;
    bus.ex_rmem_en = ld;
    bus.ex_wreg_addr = wd;
    bus.mem_req = req;
    bus.dmem_ready = rdy;
  endtask
  task automatic expect_out(input string tag, input logic [3:0] es, input logic [3:0] ef,
                            input logic er, input logic eb);
    sb.push_back('{tag, es, ef, er, eb, mcnt});
  endtask
  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ({bus.stall, bus.flush, bus.redirect_en, bus.bus_err} === {e.stall, e.flush, e.redirect, e.bus_err})
    else begin
      errors++;
      $error("FAIL %s ctrl: got stall=%b flush=%b redir=%b err=%b, expected stall=%b flush=%b redir=%b err=%b",
             e.tag, bus.stall, bus.flush, bus.redirect_en, bus.bus_err, e.stall, e.flush, e.redirect, e.bus_err);
    end
    checks++;
    assert (bus.stall_cnt === e.cnt)
    else begin
      errors++;
      $error("FAIL %s stall_cnt: got %0d expected %0d", e.tag, bus.stall_cnt, e.cnt);
    end
    if (e.stall[0] && mcnt != 4'hF) mcnt++;
  endtask
  task automatic cyc(input string tag, input logic [3:0] es, input logic [3:0] ef,
                     input logic er, input logic eb);
    expect_out(tag, es, ef, er, eb);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc("rst_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("lu_rs1", 4'b0011, 4'b0010, 1'b0, 1'b0);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("lu_bubble", 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc("lu_rs2", 4'b0011, 4'b0010, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("lu_x0", 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("lu_rs2_unused", 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    cyc("branch", 4'b0000, 4'b0001, 1'b1, 1'b0);
    drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    cyc("branch_hazard", 4'b0011, 4'b0010, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("mwait_1", 4'b1111, 4'b1000, 1'b0, 1'b0);
    bus.mem_req = 1'b0;
    cyc("mwait_2", 4'b1111, 4'b1000, 1'b0, 1'b0);
    cyc("mwait_3", 4'b1111, 4'b1000, 1'b0, 1'b0);
    bus.dmem_ready = 1'b1;
    cyc("mwait_release", 4'b0000, 4'b0000, 1'b0, 1'b0);
    bus.dmem_ready = 1'b0;
    cyc("post_release_branch", 4'b0000, 4'b0001, 1'b1, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) cyc($sformatf("tmo_%0d", i), 4'b1111, 4'b1000, 1'b0, 1'b0);
    cyc("tmo_abandon", 4'b0111, 4'b1100, 1'b0, 1'b1);
    bus.mem_req = 1'b0;
    cyc("tmo_after", 4'b0000, 4'b0000, 1'b0, 1'b0);
    bus.mem_req = 1'b1;
    cyc("rst_mw_1", 4'b1111, 4'b1000, 1'b0, 1'b0);
    bus.mem_req = 1'b0;
    #2;
    rst_n = 1'b0;
    mcnt = 4'd0;
    expect_out("rst_async", 4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    compare();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_rst_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cyc($sformatf("sat_%0d", i), 4'b0011, 4'b0010, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("sat_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
